// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx -- serial transmitter behind the MMIO UART TX register.
//
// Each change of the toggle flag uart_tx_data[8] sends one frame on tx. The
// frame carries the byte uart_tx_data[7:0] as seen at the accepting edge:
// start bit 0, then 8 data bits LSB first, then stop bit 1. Every bit lasts
// CLKS_PER_BIT clocks. The design runs on the free-running system clock.
//
// Optional feature macro: UART_TX_PARITY_EN
//   Defined   : an even-parity bit is sent between the last data bit and the
//               stop bit, giving 11*CLKS_PER_BIT cycles per frame.
//   Undefined : plain 8N1 framing, 10*CLKS_PER_BIT cycles per frame.
//
// Parameters:
//   CLK_FREQ_HZ   system clock frequency in Hz
//   BAUD_RATE     line rate in bits per second
//   CLKS_PER_BIT  clocks per serial bit, derived; must be at least 2
//
// Ports:
//   clk              system clock, all logic on posedge
//   rst              synchronous active-high reset
//   uart_tx_data     [8] toggle flag, [7:0] byte to send
//   uart_tx_sending  high while a frame is accepted or in flight
//   tx               serial line, idles high
// ---------------------------------------------------------------------------
module uart_tx #(
  parameter int CLK_FREQ_HZ  = 12_000_000,
  parameter int BAUD_RATE    = 115_200,
  parameter int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [8:0] uart_tx_data,
  output logic       uart_tx_sending,
  output logic       tx
);

  if (CLKS_PER_BIT < 2) begin : g_cpb_check
    $error("uart_tx: CLKS_PER_BIT must be at least 2");
  end

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             sending_q, sending_d;
  logic             last_toggle_q, last_toggle_d;
`ifdef UART_TX_PARITY_EN
  logic             parity_q, parity_d;
`endif

  logic request;
  logic cnt_done;

  assign request  = (uart_tx_data[8] != last_toggle_q);
  assign cnt_done = (cnt_q == '0);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    bit_idx_d     = bit_idx_q;
    shift_d       = shift_q;
    tx_d          = tx_q;
    sending_d     = sending_q;
    last_toggle_d = last_toggle_q;
`ifdef UART_TX_PARITY_EN
    parity_d      = parity_q;
`endif

    if (state_q == IDLE) begin
      tx_d      = 1'b1;
      sending_d = 1'b0;
      // The toggle is only looked at here, so any number of flips during a
      // frame collapses into one net comparison once the frame is over.
      if (request) begin
        shift_d       = uart_tx_data[7:0];
        last_toggle_d = uart_tx_data[8];
        state_d       = START;
        tx_d          = 1'b0;
        sending_d     = 1'b1;
        cnt_d         = CNT_MAX;
        bit_idx_d     = 3'd0;
`ifdef UART_TX_PARITY_EN
        parity_d      = ^uart_tx_data[7:0];
`endif
      end
    end else if (!cnt_done) begin
      cnt_d = cnt_q - 1'b1;
    end else begin
      // Bit boundary: the next bit goes onto the line on this same edge.
      cnt_d = CNT_MAX;
      case (state_q)
        START: begin
          state_d   = DATA;
          tx_d      = shift_q[0];
          shift_d   = shift_q >> 1;
          bit_idx_d = 3'd0;
        end
        DATA: begin
          if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
            tx_d    = parity_q;
`else
            state_d = STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            tx_d      = shift_q[0];
            shift_d   = shift_q >> 1;
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
`endif
        STOP: begin
          state_d   = IDLE;
          tx_d      = 1'b1;
          sending_d = 1'b0;
          cnt_d     = '0;
        end
        default: begin
          state_d   = IDLE;
          tx_d      = 1'b1;
          sending_d = 1'b0;
          cnt_d     = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      bit_idx_q     <= 3'd0;
      shift_q       <= 8'd0;
      tx_q          <= 1'b1;
      sending_q     <= 1'b0;
      // Resync to the current toggle so the power-up MMIO value (or a toggle
      // left over from an aborted frame) does not trigger a frame.
      last_toggle_q <= uart_tx_data[8];
`ifdef UART_TX_PARITY_EN
      parity_q      <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bit_idx_q     <= bit_idx_d;
      shift_q       <= shift_d;
      tx_q          <= tx_d;
      sending_q     <= sending_d;
      last_toggle_q <= last_toggle_d;
`ifdef UART_TX_PARITY_EN
      parity_q      <= parity_d;
`endif
    end
  end

  assign tx              = tx_q;
  assign uart_tx_sending = sending_q;

endmodule

// File: tb/tb_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_uart_tx -- self-checking bench for uart_tx at CLKS_PER_BIT = 4.
// Directed vectors: a table of toggle writes with hand-computed bytes and
// parity, plus hand-written sequences for back-to-back frames, double toggle
// during a frame and reset in the middle of a frame.
// ---------------------------------------------------------------------------
module tb_uart_tx;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME_CYC = NBITS * CPB;

  logic       clk = 1'b0;
  logic       rst;
  logic [8:0] uart_tx_data;
  logic       uart_tx_sending;
  logic       tx;

  int checks   = 0;
  int failures = 0;

  uart_tx #(
    .CLK_FREQ_HZ(4),
    .BAUD_RATE  (1)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .uart_tx_data   (uart_tx_data),
    .uart_tx_sending(uart_tx_sending),
    .tx             (tx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0] data;
    logic       frame;
    logic [7:0] byt;
    logic       par;
  } vec_t;

  vec_t tbl[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compares {uart_tx_sending, tx} against the required pair.
  task automatic chk(input string name, input int cyc, input logic [1:0] req);
    logic [1:0] act;
    act = {uart_tx_sending, tx};
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s cycle=%0d got sending,tx=%b required=%b", name, cyc, act, req);
    end
  endtask

  function automatic logic exp_bit(input int b, input logic [7:0] byt, input logic par);
    if (b == 0) return 1'b0;
    if (b <= 8) return byt[b-1];
`ifdef UART_TX_PARITY_EN
    if (b == 9) return par;
`endif
    return 1'b1;
  endfunction

  // Checks one frame starting right after its accepting edge. Up to two
  // writes of uart_tx_data can be injected at given frame cycles; lim limits
  // the number of cycles checked (for aborted frames).
  task automatic run_frame(input string name, input logic [7:0] byt, input logic par,
                           input int lim,
                           input int i1, input logic [8:0] d1,
                           input int i2, input logic [8:0] d2);
    for (int k = 0; k < lim; k++) begin
      chk(name, k, {1'b1, exp_bit(k / CPB, byt, par)});
      if (k == i1) uart_tx_data = d1;
      if (k == i2) uart_tx_data = d2;
      tick();
    end
  endtask

  task automatic check_idle(input string name, input int n);
    for (int k = 0; k < n; k++) begin
      chk(name, k, 2'b01);
      tick();
    end
  endtask

  initial begin
    tbl[0] = '{data: 9'h055, frame: 1'b1, byt: 8'h55, par: 1'b0};
    tbl[1] = '{data: 9'h1A5, frame: 1'b1, byt: 8'hA5, par: 1'b0};
    tbl[2] = '{data: 9'h007, frame: 1'b1, byt: 8'h07, par: 1'b1};
    tbl[3] = '{data: 9'h0FF, frame: 1'b0, byt: 8'h00, par: 1'b0};
    tbl[4] = '{data: 9'h180, frame: 1'b1, byt: 8'h80, par: 1'b1};
    tbl[5] = '{data: 9'h000, frame: 1'b1, byt: 8'h00, par: 1'b0};

    // Reset with the MMIO power-up value, then stay idle.
    rst          = 1'b1;
    uart_tx_data = 9'h1FF;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("reset", k, 2'b01);
    end
    rst = 1'b0;
    check_idle("powerup_idle", 50);

    // Table of single writes; each entry starts from idle.
    for (int i = 0; i < 6; i++) begin
      uart_tx_data = tbl[i].data;
      tick();
      if (tbl[i].frame) begin
        run_frame($sformatf("vec%0d", i), tbl[i].byt, tbl[i].par, FRAME_CYC,
                  -1, 9'h000, -1, 9'h000);
        chk($sformatf("vec%0d_end", i), FRAME_CYC, 2'b01);
      end else begin
        check_idle($sformatf("vec%0d_noframe", i), 2 * CPB);
      end
    end
    // Last toggle is now 0.

    // Back-to-back: new toggle written during the data bits of 0x55.
    uart_tx_data = 9'h155;
    tick();
    run_frame("b2b_first", 8'h55, 1'b0, FRAME_CYC, 10, 9'h0A5, -1, 9'h000);
    chk("b2b_gap", 0, 2'b01);
    tick();
    // Second frame 0xA5; toggle flipped twice during it (nets to no change).
    run_frame("b2b_second", 8'hA5, 1'b0, FRAME_CYC, 12, 9'h141, 24, 9'h042);
    check_idle("double_toggle_idle", 30);

    // Reset in the middle of data bit 3 of frame 0xC3.
    uart_tx_data = 9'h1C3;
    tick();
    run_frame("abort_frame", 8'hC3, 1'b0, 4 * CPB + 2, -1, 9'h000, -1, 9'h000);
    rst = 1'b1;
    tick();
    chk("abort_reset", 0, 2'b01);
    rst = 1'b0;
    check_idle("abort_no_resend", 30);

    // Next toggle change after the abort sends normally.
    uart_tx_data = 9'h03C;
    tick();
    run_frame("after_abort", 8'h3C, 1'b0, FRAME_CYC, 5, 9'h0F0, -1, 9'h000);
    chk("after_abort_end", FRAME_CYC, 2'b01);
    tick();
    check_idle("final_idle", 10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout got running required=finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial transmitter at the far end of the MMIO UART TX register.
- Watches the 9-bit `uart_tx_data` word from the MMIO block. Bit 8 is a toggle flag; bits 7:0 are the byte.
- Each toggle change sends one 8N1 frame on the `tx` pin.
- Reports busy status back to MMIO through `uart_tx_sending`.
- Runs on the free-running system clock. It does not use the CPU `clk_enable`.

Parameters:
- CLK_FREQ_HZ, 12_000_000, system clock frequency in Hz.
- BAUD_RATE, 115_200, line rate in bits per second.
- CLKS_PER_BIT, CLK_FREQ_HZ / BAUD_RATE (integer division, derived), clock cycles per serial bit. Elaboration must fail if CLKS_PER_BIT < 2.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- uart_tx_data  input  9  [8] toggle flag, [7:0] byte to send; driven by MMIO.
- uart_tx_sending  output  1  high while a frame is accepted or in flight.
- tx  output  1  serial line; idles high.

Behaviour:
- Clock and reset: one clock, `clk`. Reset `rst` is synchronous and active-high.
- Reset values: tx=1, uart_tx_sending=0, state=IDLE, baud counter=0, bit index=0, shift register=0.
- Reset also loads last_toggle <= uart_tx_data[8]. This prevents a spurious frame from the MMIO power-up value 9'h1FF.
- Request detection: request = (uart_tx_data[8] != last_toggle). It is evaluated only in IDLE.
- Accept edge (IDLE with request):
  - shift <= uart_tx_data[7:0], sampled at this edge.
  - last_toggle <= uart_tx_data[8].
  - state <= START, tx <= 0, uart_tx_sending <= 1, counter <= CLKS_PER_BIT-1.
  - Latency: tx falls on the first edge where the changed toggle is visible in IDLE.
- Baud counter:
  - Counts down each cycle.
  - When it reaches 0, the current bit ends, the next bit is driven on that edge, and the counter reloads to CLKS_PER_BIT-1.
  - Every bit lasts exactly CLKS_PER_BIT cycles.
- State sequence:
  - START (tx=0) -> DATA.
  - DATA: 8 bits, LSB first. tx=shift[0], shift right each bit, bit index 0..7.
  - After bit 7 -> STOP (tx=1).
  - STOP ends -> IDLE, uart_tx_sending <= 0.
  - Frame length is 10*CLKS_PER_BIT cycles from tx falling to the IDLE transition.
- Back-to-back frames: if the toggle already differs when IDLE is re-entered, the next frame is accepted on the following edge. The minimum idle-high gap between frames is 1 cycle.
- Toggle changes while busy:
  - They are not sampled mid-frame.
  - One net change is serviced after the frame. The byte is the value of [7:0] at the moment of acceptance.
  - An even number of flips during a frame nets to no change, and no frame is sent. Software polls uart_tx_sending to avoid this.
- Data bits [7:0] changing mid-frame have no effect; the byte is held in the shift register.
- Reset mid-frame: aborts immediately, tx=1 next cycle, sending=0, and last_toggle is resynced to the current toggle, so no resend.
- In IDLE, tx is held at 1.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP.
  - tx = even parity (XOR of the 8 captured data bits) for CLKS_PER_BIT cycles.
  - Frame length becomes 11*CLKS_PER_BIT.
- Undefined:
  - No PARITY state and no parity logic; 8N1 only, 10*CLKS_PER_BIT.

Test Plan:
- Reset with uart_tx_data=9'h1FF, hold 50 cycles -> tx=1 and uart_tx_sending=0 throughout; no frame.
- CLKS_PER_BIT=4: set uart_tx_data=9'h055 (toggle 1->0) -> next edge tx=0 and sending=1 for 4 cycles. Then bits 1,0,1,0,1,0,1,0, 4 cycles each. Then stop=1 for 4 cycles. sending drops after 40 cycles.
- Toggle to 9'h1A5 while the 0x55 frame is in DATA, and keep it stable -> the 0x55 frame completes unaltered, one idle cycle follows, then a 0xA5 frame: LSB-first 1,0,1,0,0,1,0,1.
- Toggle twice during one frame (9'h141 then 9'h042, with the previous toggle at 0) -> after the frame, no further frame; sending stays 0.
- Assert rst during data bit 3 -> next cycle tx=1, sending=0. Deassert -> no retransmit until the toggle next changes.
- With UART_TX_PARITY_EN defined, send 0x07 -> parity bit=1 after bit 7, then stop; total 44 cycles at CLKS_PER_BIT=4. Without the macro, the same byte takes 40 cycles.
